// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, sample types and the round-half-up/saturate helper
// used by the FIR output path.
package fir_pkg;
   localparam int IN_W = 33;
   localparam int OUT_W = 16;
   localparam int FIR_SHIFT = 15;
   localparam int DEFAULT_DECIM = 4;
   typedef logic signed [IN_W-1:0] fir_sample_t;
   typedef logic signed [OUT_W-1:0] out_sample_t;
   typedef struct packed {
      logic sat;
      out_sample_t data;
   } quant_t;
   localparam logic signed [IN_W:0] S_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [IN_W:0] S_MIN = ~S_MAX;
   // One guard bit above IN_W keeps the rounding add from wrapping.
   function automatic quant_t sat_round(input fir_sample_t x, input int shift);
      logic signed [IN_W:0] rnd;
      logic signed [IN_W:0] s;
      quant_t r;
      rnd = (IN_W+1)'(1) << (shift - 1);
      s = ($signed({x[IN_W-1], x}) + rnd) >>> shift;
      r.sat = s > S_MAX || s < S_MIN;
      r.data = s > S_MAX ? S_MAX[OUT_W-1:0] : s < S_MIN ? S_MIN[OUT_W-1:0] : s[OUT_W-1:0];
      return r;
   endfunction
endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: first-word-fall-through FIFO with a registered head so the
// output holds its last value while empty.
module fir_sync_fifo #(
   parameter int W = 16,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          valid,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] level_q, level_d;
   logic [W-1:0] dout_q, dout_d;
   logic do_push, do_pop;
   always_comb begin
      empty = level_q == '0;
      full = level_q == LW'(DEPTH);
      do_pop = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      rd_d = do_pop ? rd_q + 1'b1 : rd_q;
      level_d = level_q + LW'(do_push) - LW'(do_pop);
      // A write landing on the new head slot bypasses the memory.
      dout_d = level_d == '0 ? dout_q : (do_push && rd_d == wr_q) ? din : mem_q[rd_d];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         level_q <= '0;
         dout_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         level_q <= level_d;
         dout_q <= dout_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end
   assign dout = dout_q;
   assign valid = !empty;
   assign level = level_q;
endmodule

// File: rtl/fir_out_decimator.sv
// fir_out_decimator: requantizes the FIR sum, keeps every DECIM-th sample and
// streams it through a FIFO with saturation and drop flags.
module fir_out_decimator import fir_pkg::*; #(
   parameter int IN_W = fir_pkg::IN_W,
   parameter int OUT_W = fir_pkg::OUT_W,
   parameter int SHIFT = fir_pkg::FIR_SHIFT,
   parameter int DECIM = fir_pkg::DEFAULT_DECIM,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic signed [IN_W-1:0]         in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [OUT_W-1:0]        out_data,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           overflow,
   input  logic                           clr_ovf,
   output logic                           drop
);
   localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
   logic [PW-1:0] phase_q, phase_d;
   logic q_valid_q, q_valid_d, ovf_q, ovf_d;
   logic signed [OUT_W-1:0] q_data_q, q_data_d;
   logic keep, pop, fifo_full, fifo_empty;
   quant_t qnt;
   always_comb begin
      keep = in_valid && phase_q == '0;
      phase_d = !in_valid ? phase_q : phase_q == PW'(DECIM-1) ? '0 : phase_q + 1'b1;
      qnt = sat_round(in_data, SHIFT);
      q_valid_d = keep;
      q_data_d = keep ? qnt.data : q_data_q;
      // A new saturation outranks a clear in the same cycle.
      ovf_d = (keep && qnt.sat) || (ovf_q && !clr_ovf);
      pop = !fifo_empty && out_ready;
      drop = q_valid_q && fifo_full && !pop;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= '0;
         q_valid_q <= 1'b0;
         q_data_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         q_valid_q <= q_valid_d;
         q_data_q <= q_data_d;
         ovf_q <= ovf_d;
      end
   end
   fir_sync_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk,
      .reset,
      .push(q_valid_q),
      .din(q_data_q),
      .pop,
      .dout(out_data),
      .valid(out_valid),
      .full(fifo_full),
      .empty(fifo_empty),
      .level(fifo_level)
   );
   assign overflow = ovf_q;
endmodule

// File: tb/tb_fir_out_decimator.sv
// tb_fir_out_decimator: two instances (DECIM=4 and DECIM=1) driven in lockstep
// and compared against a queue-based sample model.
module tb_fir_out_decimator;
   logic clk = 1'b0;
   logic reset, in_valid, out_ready, clr_ovf;
   logic signed [32:0] in_data;
   logic ov [2];
   logic signed [15:0] od [2];
   logic [3:0] lvl [2];
   logic ovf [2];
   logic drp [2];
   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fir_out_decimator #(.DECIM(4)) u4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
      .fifo_level(lvl[0]), .overflow(ovf[0]), .clr_ovf(clr_ovf), .drop(drp[0])
   );
   fir_out_decimator #(.DECIM(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
      .fifo_level(lvl[1]), .overflow(ovf[1]), .clr_ovf(clr_ovf), .drop(drp[1])
   );

   int dec [2] = '{4, 1};
   int ph [2];
   bit sv [2];
   bit movf [2];
   logic signed [15:0] sd [2];
   logic signed [15:0] last [2];
   logic signed [15:0] mq0 [$];
   logic signed [15:0] mq1 [$];
   bit ob_v [2], ob_o [2], ob_dr [2], ex_v [2], ex_o [2], ex_dr [2];
   logic signed [15:0] ob_d [2], ex_d [2];
   int ob_l [2], ex_l [2];

   function automatic int qsize(input int i);
      return i == 0 ? mq0.size() : mq1.size();
   endfunction

   function automatic logic signed [15:0] qfront(input int i);
      return i == 0 ? mq0[0] : mq1[0];
   endfunction

   function automatic logic signed [15:0] ref_val(input longint x, output bit sat);
      longint s;
      s = (x + 16384) >>> 15;
      sat = s > 32767 || s < -32768;
      return s > 32767 ? 16'h7fff : s < -32768 ? 16'h8000 : 16'(s);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ph[i] = 0; sv[i] = 0; movf[i] = 0; sd[i] = '0; last[i] = '0;
      end
      mq0.delete();
      mq1.delete();
   endtask

   // Drive one cycle, record DUT and model views mid-cycle, then step the model across the edge.
   task automatic cyc(input bit iv, input logic signed [32:0] x, input bit ordy, input bit clr);
      bit sat, pop_now, kp;
      logic signed [15:0] v;
      in_valid = iv; in_data = x; out_ready = ordy; clr_ovf = clr;
      #1;
      for (int i = 0; i < 2; i++) begin
         ex_v[i] = qsize(i) > 0;
         ex_d[i] = ex_v[i] ? qfront(i) : last[i];
         ex_l[i] = qsize(i);
         ex_o[i] = movf[i];
         ex_dr[i] = sv[i] && qsize(i) == 8 && !ordy;
         ob_v[i] = ov[i]; ob_d[i] = od[i]; ob_l[i] = int'(lvl[i]);
         ob_o[i] = ovf[i]; ob_dr[i] = drp[i];
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         pop_now = qsize(i) > 0 && ordy;
         if (pop_now) last[i] = (i == 0) ? mq0.pop_front() : mq1.pop_front();
         if (sv[i] && qsize(i) < 8) begin
            if (i == 0) mq0.push_back(sd[i]); else mq1.push_back(sd[i]);
         end
         kp = iv && ph[i] == 0;
         v = ref_val(longint'(x), sat);
         movf[i] = (kp && sat) || (movf[i] && !clr);
         sv[i] = kp;
         if (kp) sd[i] = v;
         if (iv) ph[i] = (ph[i] + 1) % dec[i];
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; clr_ovf = 0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; clr_ovf = 0;
      model_reset();
      #12;
      for (int i = 0; i < 2; i++) begin
         checks += 5;
         if (ov[i] !== 1'b0) begin errs++; $display("FAIL reset out_valid[%0d]: got %b exp 0", i, ov[i]); end
         if (lvl[i] !== 4'd0) begin errs++; $display("FAIL reset level[%0d]: got %0d exp 0", i, lvl[i]); end
         if (od[i] !== 16'sd0) begin errs++; $display("FAIL reset out_data[%0d]: got %0d exp 0", i, od[i]); end
         if (ovf[i] !== 1'b0) begin errs++; $display("FAIL reset overflow[%0d]: got %b exp 0", i, ovf[i]); end
         if (drp[i] !== 1'b0) begin errs++; $display("FAIL reset drop[%0d]: got %b exp 0", i, drp[i]); end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) cyc(1, 33'(k * 32768), 0, 0);
      cyc(0, '0, 0, 0);
      checks++;
      if (lvl[1] !== 4'd3) begin errs++; $display("FAIL midreset prefill level: got %0d exp 3", lvl[1]); end
      #2;
      reset = 1'b1;
      #1;
      checks += 3;
      if (ov[1] !== 1'b0) begin errs++; $display("FAIL midreset out_valid: got %b exp 0", ov[1]); end
      if (lvl[1] !== 4'd0) begin errs++; $display("FAIL midreset level: got %0d exp 0", lvl[1]); end
      if (ovf[1] !== 1'b0) begin errs++; $display("FAIL midreset overflow: got %b exp 0", ovf[1]); end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(1, 33'(5 * 32768), 0, 0);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 0, 0);
      checks += 2;
      if (!(ob_v[0] === 1'b1 && ob_d[0] === 16'sd5)) begin
         errs++; $display("FAIL midreset phase0 keep: got v=%b d=%0d exp v=1 d=5", ob_v[0], ob_d[0]);
      end
      if (ob_l[1] !== 1) begin errs++; $display("FAIL midreset first level: got %0d exp 1", ob_l[1]); end
   endtask

   task automatic test_decim();
      int first;
      logic signed [15:0] got [$];
      do_reset();
      first = -1;
      for (int k = 0; k < 20; k++) begin
         cyc(k < 16, 33'(k * 32768), 1, 0);
         if (ob_v[0]) begin
            if (first < 0) first = k;
            got.push_back(ob_d[0]);
         end
      end
      checks += 2;
      if (first !== 2) begin errs++; $display("FAIL decim latency: got %0d exp 2", first); end
      if (got.size() !== 4) begin errs++; $display("FAIL decim count: got %0d exp 4", got.size()); end
      for (int j = 0; j < got.size() && j < 4; j++) begin
         checks++;
         if (got[j] !== 16'(j * 4)) begin errs++; $display("FAIL decim out[%0d]: got %0d exp %0d", j, got[j], j * 4); end
      end
   endtask

   task automatic test_round();
      longint vals [5] = '{16384, -16384, 49152, -49152, 32767};
      int expv [5] = '{1, 0, 2, -1, 1};
      logic signed [15:0] got [$];
      bit seen;
      do_reset();
      seen = 0;
      for (int k = 0; k < 9; k++) begin
         cyc(k < 5, k < 5 ? 33'(vals[k]) : '0, 1, 0);
         if (ob_v[1]) got.push_back(ob_d[1]);
         seen |= ob_o[1];
      end
      checks += 3;
      if (got.size() !== 5) begin errs++; $display("FAIL round count: got %0d exp 5", got.size()); end
      if (seen || ovf[1] !== 1'b0) begin errs++; $display("FAIL round overflow: got seen=%b now=%b exp 0", seen, ovf[1]); end
      if (ovf[0] !== 1'b0) begin errs++; $display("FAIL round overflow decim4: got %b exp 0", ovf[0]); end
      for (int j = 0; j < got.size() && j < 5; j++) begin
         checks++;
         if (got[j] !== 16'(expv[j])) begin errs++; $display("FAIL round out[%0d]: got %0d exp %0d", j, got[j], expv[j]); end
      end
   endtask

   task automatic test_sat();
      logic signed [15:0] got [$];
      do_reset();
      cyc(1, 33'sd2147483648, 1, 0);
      if (ob_v[1]) got.push_back(ob_d[1]);
      cyc(1, -33'sd2147483648, 1, 0);
      if (ob_v[1]) got.push_back(ob_d[1]);
      for (int k = 0; k < 2; k++) begin
         cyc(0, '0, 1, 0);
         if (ob_v[1]) got.push_back(ob_d[1]);
      end
      checks += 2;
      if (got.size() !== 2 || got[0] !== 16'sh7fff || got[1] !== 16'sh8000) begin
         errs++; $display("FAIL sat values: got n=%0d %0d %0d exp 32767 -32768", got.size(), got.size() > 0 ? got[0] : 16'sd0, got.size() > 1 ? got[1] : 16'sd0);
      end
      if (ovf[1] !== 1'b1) begin errs++; $display("FAIL sat overflow set: got %b exp 1", ovf[1]); end
      cyc(0, '0, 1, 1);
      checks++;
      if (ovf[1] !== 1'b0) begin errs++; $display("FAIL sat clr alone: got %b exp 0", ovf[1]); end
      cyc(1, 33'sd2147483648, 1, 1);
      checks++;
      if (ovf[1] !== 1'b1) begin errs++; $display("FAIL sat set beats clr: got %b exp 1", ovf[1]); end
      cyc(0, '0, 1, 1);
   endtask

   task automatic test_backpressure();
      int drops, drop_at;
      logic signed [15:0] got [$];
      do_reset();
      drops = 0; drop_at = -1;
      for (int k = 0; k < 11; k++) begin
         cyc(k < 9, 33'((k + 1) * 32768), 0, 0);
         if (ob_dr[1]) begin drops++; drop_at = k; end
      end
      checks += 3;
      if (drops !== 1) begin errs++; $display("FAIL bp drop count: got %0d exp 1", drops); end
      if (drop_at !== 9) begin errs++; $display("FAIL bp drop cycle: got %0d exp 9", drop_at); end
      if (lvl[1] !== 4'd8) begin errs++; $display("FAIL bp full level: got %0d exp 8", lvl[1]); end
      for (int k = 0; k < 12; k++) begin
         cyc(0, '0, 1, 0);
         if (ob_v[1]) got.push_back(ob_d[1]);
      end
      checks += 2;
      if (got.size() !== 8) begin errs++; $display("FAIL bp drain count: got %0d exp 8", got.size()); end
      if (lvl[1] !== 4'd0) begin errs++; $display("FAIL bp drained level: got %0d exp 0", lvl[1]); end
      for (int j = 0; j < got.size() && j < 8; j++) begin
         checks++;
         if (got[j] !== 16'(j + 1)) begin errs++; $display("FAIL bp out[%0d]: got %0d exp %0d", j, got[j], j + 1); end
      end
   endtask

   task automatic test_full_pushpop();
      logic signed [15:0] got [$];
      do_reset();
      for (int k = 0; k < 9; k++) cyc(k < 8, 33'((k + 10) * 32768), 0, 0);
      checks++;
      if (lvl[1] !== 4'd8) begin errs++; $display("FAIL full prefill level: got %0d exp 8", lvl[1]); end
      cyc(1, 33'(18 * 32768), 0, 0);
      cyc(0, '0, 1, 0);
      checks += 3;
      if (ob_dr[1] !== 1'b0) begin errs++; $display("FAIL full pushpop drop: got %b exp 0", ob_dr[1]); end
      if (!(ob_v[1] === 1'b1 && ob_d[1] === 16'sd10)) begin errs++; $display("FAIL full pushpop head: got v=%b d=%0d exp v=1 d=10", ob_v[1], ob_d[1]); end
      if (lvl[1] !== 4'd8) begin errs++; $display("FAIL full pushpop level: got %0d exp 8", lvl[1]); end
      for (int k = 0; k < 10; k++) begin
         cyc(0, '0, 1, 0);
         if (ob_v[1]) got.push_back(ob_d[1]);
      end
      checks++;
      if (got.size() !== 8) begin errs++; $display("FAIL full drain count: got %0d exp 8", got.size()); end
      for (int j = 0; j < got.size() && j < 8; j++) begin
         checks++;
         if (got[j] !== 16'(j + 11)) begin errs++; $display("FAIL full out[%0d]: got %0d exp %0d", j, got[j], j + 11); end
      end
   endtask

   task automatic test_random();
      logic signed [32:0] r;
      int mode;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         r = 33'({$urandom(), $urandom()});
         mode = $urandom_range(0, 3);
         r = mode == 0 ? r : mode == 1 ? r >>> 2 : r >>> 12;
         cyc($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         for (int i = 0; i < 2; i++) begin
            checks += 5;
            if (ob_v[i] !== ex_v[i]) begin errs++; $display("FAIL rand valid[%0d] n=%0d: got %b exp %b", i, n, ob_v[i], ex_v[i]); end
            if (ob_d[i] !== ex_d[i]) begin errs++; $display("FAIL rand data[%0d] n=%0d: got %0d exp %0d", i, n, ob_d[i], ex_d[i]); end
            if (ob_l[i] !== ex_l[i]) begin errs++; $display("FAIL rand level[%0d] n=%0d: got %0d exp %0d", i, n, ob_l[i], ex_l[i]); end
            if (ob_o[i] !== ex_o[i]) begin errs++; $display("FAIL rand overflow[%0d] n=%0d: got %b exp %b", i, n, ob_o[i], ex_o[i]); end
            if (ob_dr[i] !== ex_dr[i]) begin errs++; $display("FAIL rand drop[%0d] n=%0d: got %b exp %b", i, n, ob_dr[i], ex_dr[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_decim();
      test_round();
      test_sat();
      test_backpressure();
      test_full_pushpop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/fir_out_decimator.md
Name: fir_out_decimator

Overview:
Output stage placed directly downstream of the FIR filter.
- Takes the FIR's full-width signed sum and requantizes it to OUT_W bits, using round-half-up on the shift followed by saturation.
- Decimates the sample stream by DECIM.
- Buffers the kept samples in a small FIFO and presents them on a valid/ready interface to the consumer (DAC/host streaming).
- Flags saturation and dropped samples.

Parameters:
IN_W, 33, width of the signed input sample; matches the FIR output.
OUT_W, 16, width of the signed output sample.
SHIFT, 15, arithmetic right shift applied to the input; removes the Q15 coefficient gain.
DECIM, 4, decimation factor; must be at least 1, where 1 means pass-through.
FIFO_DEPTH, 8, output FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  single system clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  in_data is valid this cycle; tied high when driven by the free-running FIR.
in_data  in  IN_W  signed FIR output sample.
out_valid  out  1  FIFO head is valid.
out_ready  in  1  consumer accepts the head when out_valid is high.
out_data  out  OUT_W  signed FIFO head; first-word-fall-through.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky flag: a kept sample saturated.
clr_ovf  in  1  synchronous clear of overflow.
drop  out  1  one-cycle pulse: a kept sample was discarded because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-high):
  - Decimation phase counter = 0, stage register invalid.
  - FIFO empty, with pointers at 0.
  - out_valid=0, out_data=0, fifo_level=0, overflow=0, drop=0.
  - Reset asserted mid-stream discards all buffered samples; the first in_valid after release is phase 0.
- Decimation:
  - Phase counter runs 0..DECIM-1.
  - It advances only on cycles with in_valid=1 and wraps DECIM-1 -> 0.
  - The sample presented at phase 0 is kept; all others are discarded.
- Quantization of a kept sample, in IN_W+1-bit signed arithmetic:
  - s = (sext(in_data) + 2^(SHIFT-1)) >>> SHIFT.
  - If s > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1 and set overflow.
  - If s < -2^(OUT_W-1), output -2^(OUT_W-1) and set overflow.
  - Otherwise output s[OUT_W-1:0].
- Pipeline timing:
  - The kept sample is captured into the stage register (q_valid, q_data) at edge n.
  - It is written to the FIFO at edge n+1.
  - out_valid is high in the cycle following edge n+1, i.e. 2-cycle latency from in_valid to out_valid when the FIFO is empty.
- FIFO push/pop:
  - Push when q_valid=1.
  - Pop when out_valid and out_ready are both 1.
  - Push and pop may occur together in any state, including full; a simultaneous push+pop at full succeeds and leaves the level unchanged with no drop.
  - Push at full with no pop: the sample is discarded, drop=1 for exactly that cycle, and FIFO contents are unchanged.
  - Empty: out_valid=0 and out_data holds its last value (0 after reset); out_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by the extra bit in level.
- overflow:
  - Set on the cycle a saturating sample enters the stage register; held until clr_ovf.
  - If set and clr_ovf occur in the same cycle, set wins.
- out_data, out_valid and fifo_level are registered or driven directly from FIFO state; there is no combinational path from in_* to out_*.

Decomposition:
- Shared package fir_pkg:
  - Widths: IN_W=33, OUT_W=16.
  - FIR_SHIFT=15, DEFAULT_DECIM=4.
  - Typedefs fir_sample_t (logic signed [32:0]) and out_sample_t (logic signed [15:0]).
  - A sat_round function implementing the quantization rule above.
- One sub-module: fir_sync_fifo.
  - Parameterized width and depth; FWFT; push/pop/full/empty/level.
  - Instantiated once; reusable for the upstream input buffer.

Test Plan:
1. Reset mid-stream with 3 samples buffered -> out_valid=0 and fifo_level=0 immediately; overflow=0; the first sample after release is kept (phase 0).
2. DECIM=4, out_ready=1, in_data=k*32768 for k=0..15 on consecutive cycles -> outputs 0,4,8,12 in order; first out_valid 2 cycles after k=0 is presented.
3. Rounding, with DECIM=1 and SHIFT=15:
   - in=16384 -> 1
   - in=-16384 -> 0
   - in=49152 -> 2
   - in=-49152 -> -1
   - in=32767 -> 1
   - overflow stays 0 throughout.
4. Saturation: in=2^31 -> 32767 and overflow=1; in=-2^31 -> -32768. clr_ovf pulsed alone -> overflow=0. clr_ovf in the same cycle as a saturating sample -> overflow=1.
5. Backpressure, DECIM=1, out_ready=0, 9 kept samples 1..9:
   - fifo_level=8; drop pulses once, on sample 9.
   - Then out_ready=1 -> outputs 1..8 in order, and fifo_level returns to 0.
6. FIFO full with out_ready=1 and a new push in the same cycle -> no drop; fifo_level stays 8; the popped value is the oldest entry and the new value is appended last.
